// File: rtl/exec_stage_mdu.sv
// Execute stage: operand forwarding, combinational ALU and an iterative multiply/divide unit.
// The divider is only built when EXEC_STAGE_MDU_DIV_EN is defined.
module exec_stage_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] rd1_i,
    input  logic [WIDTH-1:0] rd2_i,
    input  logic [WIDTH-1:0] alu_out_im_i,
    input  logic [WIDTH-1:0] res_iwb_i,
    input  logic [1:0]       fwd_a_i,
    input  logic [1:0]       fwd_b_i,
    input  logic [WIDTH-1:0] sign_imm_i,
    input  logic             b_sel_i,
    input  logic [2:0]       alu_ctrl_i,
    input  logic             md_start_i,
    input  logic [1:0]       md_op_i,
    input  logic [1:0]       res_sel_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [WIDTH-1:0] write_data_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    logic [WIDTH-1:0] src_a, src_b, alu_b, alu_res;

    always_comb begin
        src_a = rd1_i;
        if (fwd_a_i[1])      src_a = alu_out_im_i;
        else if (fwd_a_i[0]) src_a = res_iwb_i;
        src_b = rd2_i;
        if (fwd_b_i[1])      src_b = alu_out_im_i;
        else if (fwd_b_i[0]) src_b = res_iwb_i;
        alu_b = b_sel_i ? sign_imm_i : src_b;
    end

    always_comb begin
        alu_res = '0;
        case (alu_ctrl_i)
            3'b000: alu_res = src_a + alu_b;
            3'b001: alu_res = src_a - alu_b;
            3'b010: alu_res = src_a & alu_b;
            3'b011: alu_res = src_a | alu_b;
            3'b100: alu_res = src_a ^ alu_b;
            3'b101: alu_res = ~(src_a | alu_b);
            3'b110: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(alu_b))};
            default: alu_res = {{(WIDTH-1){1'b0}}, (src_a < alu_b)};
        endcase
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    assign zero_o       = (alu_res == '0);
    assign write_data_o = src_b;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign busy_o       = (state != S_IDLE);
    assign done_o       = done_q;

    always_comb begin
        result_o = alu_res;
        if (res_sel_i == 2'b01)      result_o = hi_q;
        else if (res_sel_i == 2'b10) result_o = lo_q;
    end

    logic start_acc, mdu_start;
    assign start_acc = (state == S_IDLE) && md_start_i;

    // acc: running product high half / partial remainder; sh: multiplier / quotient
    logic [WIDTH-1:0]   acc, sh, mcand;
    logic               res_neg;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   step_acc, step_sh, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef EXEC_STAGE_MDU_DIV_EN
    logic           is_div, rem_neg, div_zero;
    logic [WIDTH:0] rem_sh;
    assign mdu_start = start_acc;
`else
    logic nodiv_start;
    assign mdu_start   = start_acc && !md_op_i[1];
    assign nodiv_start = start_acc && md_op_i[1];
`endif

    always_comb begin
        sum_w    = {1'b0, acc} + (sh[0] ? {1'b0, mcand} : '0);
        step_acc = sum_w[WIDTH:1];
        step_sh  = {sum_w[0], sh[WIDTH-1:1]};
        prod_fix = cond_neg2({acc, sh}, res_neg);
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
`ifdef EXEC_STAGE_MDU_DIV_EN
        rem_sh = {acc, sh[WIDTH-1]};
        if (is_div) begin
            if (rem_sh >= {1'b0, mcand}) begin
                step_acc = rem_sh[WIDTH-1:0] - mcand;
                step_sh  = {sh[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = rem_sh[WIDTH-1:0];
                step_sh  = {sh[WIDTH-2:0], 1'b0};
            end
            // zero divisor leaves acc = |dividend|, so the sign fix restores the dividend
            fix_hi = rem_neg ? -acc : acc;
            fix_lo = div_zero ? '1 : (res_neg ? -sh : sh);
        end
`endif
    end

    // Datapath: operands captured on start, one iteration per RUN cycle
    always_ff @(posedge clk_i) begin
        if (mdu_start) begin
            acc     <= '0;
            sh      <= mag_of(src_a, md_op_i[0]);
            mcand   <= mag_of(src_b, md_op_i[0]);
            res_neg <= md_op_i[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef EXEC_STAGE_MDU_DIV_EN
            is_div   <= md_op_i[1];
            rem_neg  <= md_op_i[0] & src_a[WIDTH-1];
            div_zero <= (src_b == '0);
`endif
        end else if (state == S_RUN) begin
            acc <= step_acc;
            sh  <= step_sh;
        end
    end

    // Control: FSM, iteration counter, HI/LO and completion pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mdu_start) begin
                        state <= S_RUN;
                        cnt   <= CNT_W'(WIDTH);
                    end
`ifndef EXEC_STAGE_MDU_DIV_EN
                    if (nodiv_start) done_q <= 1'b1;
`endif
                end
                S_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage_mdu.sv
// Directed bench for exec_stage_mdu (WIDTH = 32); divide checks depend on EXEC_STAGE_MDU_DIV_EN.
module tb_exec_stage_mdu;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] rd1_i = '0, rd2_i = '0, alu_out_im_i = '0, res_iwb_i = '0, sign_imm_i = '0;
    logic [1:0]   fwd_a_i = '0, fwd_b_i = '0, md_op_i = '0, res_sel_i = '0;
    logic         b_sel_i = 1'b0, md_start_i = 1'b0;
    logic [2:0]   alu_ctrl_i = '0;
    logic [W-1:0] result_o, write_data_o, hi_o, lo_o;
    logic         zero_o, busy_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;

    exec_stage_mdu #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
        .alu_out_im_i(alu_out_im_i), .res_iwb_i(res_iwb_i), .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i),
        .sign_imm_i(sign_imm_i), .b_sel_i(b_sel_i), .alu_ctrl_i(alu_ctrl_i),
        .md_start_i(md_start_i), .md_op_i(md_op_i), .res_sel_i(res_sel_i),
        .result_o(result_o), .zero_o(zero_o), .write_data_o(write_data_o),
        .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int nbusy, output int ndone_early);
        rd1_i = a; rd2_i = b; fwd_a_i = 2'b00; fwd_b_i = 2'b00;
        b_sel_i = 1'b1; sign_imm_i = 32'h1234_5678;
        md_op_i = op; md_start_i = 1'b1;
        tick();
        md_start_i = 1'b0;
        nbusy = 0; ndone_early = 0;
        while (busy_o && nbusy < 100) begin
            nbusy++;
            if (done_o) ndone_early++;
            tick();
        end
        b_sel_i = 1'b0;
    endtask

    logic [W-1:0] alu_exp [8] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};

    initial begin
        int nb, ne, nd, bad;
        logic [W-1:0] lo_at_done, hi_prev, lo_prev;

        // reset values while rst_i is held
        #2;
        check("rst_busy", 64'(busy_o), 64'(1'b0));
        check("rst_done", 64'(done_o), 64'(1'b0));
        check("rst_hi",   64'(hi_o),   64'(0));
        check("rst_lo",   64'(lo_o),   64'(0));
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // MULT -3 * 0x7FFFFFFF, started on the first edge after reset release
        run_op(2'b01, 32'hFFFF_FFFD, 32'h7FFF_FFFF, nb, ne);
        check("mult_busy_cycles", 64'(nb), 64'(33));
        check("mult_done_early",  64'(ne), 64'(0));
        check("mult_done",        64'(done_o), 64'(1'b1));
        check("mult_hi",          64'(hi_o), 64'(32'hFFFF_FFFE));
        check("mult_lo",          64'(lo_o), 64'(32'h8000_0003));
        tick();
        check("mult_done_once",   64'(done_o), 64'(1'b0));

        // forwarding into the ALU
        rd1_i = 32'd5; alu_out_im_i = 32'd7; fwd_a_i = 2'b10;
        rd2_i = 32'd3; fwd_b_i = 2'b00; b_sel_i = 1'b0; alu_ctrl_i = 3'b000; res_sel_i = 2'b00;
        #1;
        check("fwd_add_result", 64'(result_o), 64'(32'd10));
        check("fwd_add_zero",   64'(zero_o), 64'(1'b0));
        check("fwd_wdata_rd2",  64'(write_data_o), 64'(32'd3));
        fwd_b_i = 2'b01; res_iwb_i = 32'hFFFF_FFF9;
        #1;
        check("fwd_iwb_result", 64'(result_o), 64'(0));
        check("fwd_iwb_zero",   64'(zero_o), 64'(1'b1));
        check("fwd_wdata_iwb",  64'(write_data_o), 64'(32'hFFFF_FFF9));
        res_sel_i = 2'b01;
        #1;
        check("ressel_hi",      64'(result_o), 64'(32'hFFFF_FFFE));
        check("ressel_zero",    64'(zero_o), 64'(1'b1));
        res_sel_i = 2'b11;
        #1;
        check("ressel_11_alu",  64'(result_o), 64'(0));

        // ALU operations with A = -1, B = 1
        fwd_a_i = 2'b00; fwd_b_i = 2'b00; rd1_i = 32'hFFFF_FFFF; rd2_i = 32'd1; res_sel_i = 2'b00;
        for (int i = 0; i < 8; i++) begin
            alu_ctrl_i = 3'(i);
            #1;
            check($sformatf("alu_op%0d", i), 64'(result_o), 64'(alu_exp[i]));
            check($sformatf("alu_zero%0d", i), 64'(zero_o), 64'(alu_exp[i] == '0));
        end
        b_sel_i = 1'b1; sign_imm_i = 32'h10; rd1_i = 32'hFF; alu_ctrl_i = 3'b010;
        #1;
        check("alu_imm_and", 64'(result_o), 64'(32'h10));
        fwd_a_i = 2'b01; res_iwb_i = 32'h100; alu_ctrl_i = 3'b011;
        #1;
        check("alu_fwd01_or", 64'(result_o), 64'(32'h110));
        fwd_a_i = 2'b11; alu_out_im_i = 32'h20;
        #1;
        check("alu_fwd11_or", 64'(result_o), 64'(32'h30));
        b_sel_i = 1'b0; fwd_a_i = 2'b00;

        // MULTU full-width carry case
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, ne);
        check("multu_busy_cycles", 64'(nb), 64'(33));
        check("multu_hi", 64'(hi_o), 64'(32'hFFFF_FFFE));
        check("multu_lo", 64'(lo_o), 64'(32'h0000_0001));
        tick();

        // start held for 40 cycles; operands changed mid-run must not be picked up
        rd1_i = 32'd7; rd2_i = 32'd6; fwd_a_i = 2'b00; fwd_b_i = 2'b00;
        md_op_i = 2'b00; res_sel_i = 2'b10; md_start_i = 1'b1;
        nd = 0; lo_at_done = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_o) begin
                nd++;
                lo_at_done = lo_o;
            end
            if (k == 4) begin
                rd1_i = 32'd9; rd2_i = 32'd9;
            end
            if (k == 10) begin
                check("hold_busy",        64'(busy_o), 64'(1'b1));
                check("hold_result_oldlo", 64'(result_o), 64'(32'h0000_0001));
                check("hold_lo_old",      64'(lo_o), 64'(32'h0000_0001));
            end
        end
        md_start_i = 1'b0;
        check("hold_one_done", 64'(nd), 64'(1));
        check("hold_first_lo", 64'(lo_at_done), 64'(32'd42));
        nb = 0;
        while (busy_o && nb < 100) begin
            nb++;
            tick();
        end
        check("hold_second_idle", 64'(busy_o), 64'(1'b0));
        check("hold_second_lo",   64'(lo_o), 64'(32'd81));
        check("hold_second_hi",   64'(hi_o), 64'(0));
        tick();
        res_sel_i = 2'b00;

`ifdef EXEC_STAGE_MDU_DIV_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, nb, ne);
        check("div_busy_cycles", 64'(nb), 64'(33));
        check("div_done",        64'(done_o), 64'(1'b1));
        check("div_lo",          64'(lo_o), 64'(32'hFFFF_FFFD));
        check("div_hi",          64'(hi_o), 64'(32'hFFFF_FFFF));
        tick();
        run_op(2'b10, 32'd7, 32'd0, nb, ne);
        check("divu0_busy_cycles", 64'(nb), 64'(33));
        check("divu0_lo",          64'(lo_o), 64'(32'hFFFF_FFFF));
        check("divu0_hi",          64'(hi_o), 64'(32'd7));
        tick();
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, nb, ne);
        check("divmin_lo", 64'(lo_o), 64'(32'h8000_0000));
        check("divmin_hi", 64'(hi_o), 64'(0));
        tick();
        run_op(2'b10, 32'd100, 32'd7, nb, ne);
        check("divu_lo", 64'(lo_o), 64'(32'd14));
        check("divu_hi", 64'(hi_o), 64'(32'd2));
        tick();
`else
        hi_prev = hi_o;
        lo_prev = lo_o;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, nb, ne);
        check("nodiv_busy_cycles", 64'(nb), 64'(0));
        check("nodiv_done",        64'(done_o), 64'(1'b1));
        check("nodiv_hi",          64'(hi_o), 64'(hi_prev));
        check("nodiv_lo",          64'(lo_o), 64'(lo_prev));
        tick();
        check("nodiv_done_once",   64'(done_o), 64'(1'b0));
`endif

        // reset in the middle of a MULTU
        rd1_i = 32'd5; rd2_i = 32'd5; md_op_i = 2'b00; md_start_i = 1'b1;
        tick();
        md_start_i = 1'b0;
        repeat (10) tick();
        check("midrst_busy_before", 64'(busy_o), 64'(1'b1));
        rst_i = 1'b1;
        #1;
        check("midrst_busy", 64'(busy_o), 64'(1'b0));
        check("midrst_hi",   64'(hi_o),   64'(0));
        check("midrst_lo",   64'(lo_o),   64'(0));
        check("midrst_done", 64'(done_o), 64'(1'b0));
        tick();
        tick();
        rst_i = 1'b0;
        bad = 0;
        repeat (40) begin
            tick();
            if (done_o || busy_o) bad++;
        end
        check("midrst_no_done", 64'(bad), 64'(0));
        check("midrst_lo_kept", 64'(lo_o), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_stage_mdu.md
EXEC_STAGE_MDU -- requirements
Module: exec_stage_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width in bits (legal values 8..64, even).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have ports rd1_i and rd2_i, input, WIDTH each: register-file operands A and B.
REQ-005 SHALL have ports alu_out_im_i and res_iwb_i, input, WIDTH each: memory-stage and writeback-stage forwarding values.
REQ-006 SHALL have ports fwd_a_i and fwd_b_i, input, 2 each: forwarding selects; 00 = rd, 01 = res_iwb_i, 1x = alu_out_im_i.
REQ-007 SHALL have ports sign_imm_i (input, WIDTH) and b_sel_i (input, 1): ALU B source; 0 = forwarded B, 1 = sign_imm_i.
REQ-008 SHALL have port alu_ctrl_i, input, 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu.
REQ-009 SHALL have ports md_start_i (input, 1) and md_op_i (input, 2): start a multiply/divide; op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-010 SHALL have port res_sel_i, input, 2: result_o source; 00 ALU, 01 HI, 10 LO, 11 ALU.
REQ-011 SHALL have ports result_o (output, WIDTH), zero_o (output, 1), write_data_o (output, WIDTH; the forwarded B value).
REQ-012 SHALL have ports hi_o and lo_o (output, WIDTH each), busy_o (output, 1; stall request), and done_o (output, 1; completion pulse).

Function
REQ-013 ALU path SHALL be combinational; zero_o = (ALU result == 0) regardless of res_sel_i; slt/sltu SHALL yield 1 or 0 zero-extended to WIDTH.
REQ-014 add/sub SHALL wrap modulo 2^WIDTH; overflow is not flagged.
REQ-015 MDU FSM SHALL have states IDLE, RUN, FIX; busy_o = (state != IDLE), and done_o is a registered output.
REQ-016 In IDLE, md_start_i high at a clock edge SHALL latch both forwarded operands and md_op_i, load the iteration counter with WIDTH, and move to RUN.
REQ-017 Signed ops SHALL iterate on operand magnitudes and record the result signs at start.
REQ-018 RUN SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle, decrement the counter, and move to FIX once the counter reaches 1.
REQ-019 FIX SHALL apply sign correction, write HI/LO at its closing edge, move to IDLE, and set done_o high for exactly the following cycle.
REQ-020 Multiply SHALL write HI:LO = full 2*WIDTH product; divide SHALL write LO = quotient and HI = remainder (truncating; remainder takes the dividend's sign).
REQ-021 Divide by zero SHALL write LO = all ones and HI = dividend, with the same latency.
REQ-022 Signed most-negative / -1 SHALL write LO = most-negative and HI = 0.
REQ-023 Latency SHALL be fixed: HI/LO are updated WIDTH+1 edges after the start edge, and busy_o is high for exactly WIDTH+1 cycles.
REQ-024 md_start_i while busy_o is high SHALL be ignored, with no restart and no queuing.
REQ-025 hi_o/lo_o SHALL hold their old values until the FIX write; result_o with res_sel_i = 01/10 during busy SHALL return the old HI/LO.

Reset
REQ-026 rst_i high SHALL immediately force state IDLE, counter 0, HI = 0, LO = 0, done_o = 0, and busy_o = 0, including mid-operation; an operation in flight is discarded.
REQ-027 The first start SHALL be accepted at the first rising edge after rst_i deasserts.

Configuration
REQ-028 With macro EXEC_STAGE_MDU_DIV_EN defined, divide ops SHALL behave as REQ-018..REQ-022.
REQ-029 Without EXEC_STAGE_MDU_DIV_EN, no divider logic is built: DIVU/DIV starts SHALL be accepted, keep busy_o low, leave HI/LO unchanged, and pulse done_o the next cycle.

Verification
REQ-030 The bench SHALL cover forwarding: rd1_i=5, alu_out_im_i=7, fwd_a_i=10, rd2_i=3, add -> result_o=10, zero_o=0; with fwd_b_i=01 and res_iwb_i=-7 -> result_o=0, zero_o=1.
REQ-031 The bench SHALL cover MULT: WIDTH=32, A=-3, B=0x7FFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x80000003, and done_o pulses once.
REQ-032 The bench SHALL cover DIV: A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 The bench SHALL cover busy behaviour: md_start_i held high for 40 cycles -> exactly one operation; with res_sel_i=10 during busy, result_o equals the previous LO.
REQ-034 The bench SHALL cover reset mid-operation: rst_i asserted 10 cycles into MULTU -> busy_o=0 and HI=LO=0 immediately, with no done_o.
REQ-035 The bench SHALL build without EXEC_STAGE_MDU_DIV_EN, issue DIV -> busy_o stays 0, done_o high one cycle later, HI/LO unchanged.
